// File: rtl/dump_pkg.sv
// Shared definitions for the BRAM-to-UART sample dumper: FSM encoding,
// sync-header bytes and the width of one transmitted frame word.
package dump_pkg;

  localparam int FRAME_W = 16;

  localparam logic [7:0] SYNC_HI = 8'hA5;
  localparam logic [7:0] SYNC_LO = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_READ,
    ST_WAIT,
    ST_SEND_HI,
    ST_SEND_LO,
    ST_NEXT
  } state_t;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, idle high. A byte is taken when valid
// is high while idle; idle drops the following cycle until the stop bit ends.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       i_reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       tx,
  output logic       idle
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic             busy;
  logic [3:0]       bit_idx;
  logic [CNT_W-1:0] clk_cnt;
  logic [9:0]       shreg;

  assign idle = ~busy;

  // Frame layout: bit 0 start, bits 1..8 data LSB first, bit 9 stop.
  always_ff @(posedge clock) begin
    if (!busy && valid) shreg <= {1'b1, data, 1'b0};
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      busy    <= 1'b0;
      bit_idx <= 4'd0;
      clk_cnt <= '0;
      tx      <= 1'b1;
    end else if (!busy) begin
      if (valid) begin
        busy    <= 1'b1;
        bit_idx <= 4'd0;
        clk_cnt <= '0;
        tx      <= 1'b0;
      end
    end else if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
      clk_cnt <= '0;
      if (bit_idx == 4'd9) begin
        busy <= 1'b0;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= shreg[bit_idx + 4'd1];
      end
    end else begin
      clk_cnt <= clk_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bram_uart_dump.sv
// Reads DEPTH samples from a capture BRAM and streams each as a sign-extended
// 16-bit word (high byte first) over UART. Define BRAM_DUMP_HEADER_EN to prefix
// every frame with the sync bytes A5 5A.
module bram_uart_dump
  import dump_pkg::*;
#(
  parameter int NB_ADDR      = 11,
  parameter int NB_DATA      = 14,
  parameter int DEPTH        = 2048,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_start,
  output logic [NB_ADDR-1:0] o_read_addr,
  output logic               o_read_enable,
  input  logic [NB_DATA-1:0] i_read_data,
  output logic               o_tx,
  output logic               o_busy,
  output logic               o_done
);

  state_t                     state, state_next;
  logic [NB_ADDR-1:0]         addr, addr_next;
  logic signed [FRAME_W-1:0]  sample;
  logic [7:0]                 tx_byte;
  logic                       tx_valid, tx_idle;
  logic                       last;
  logic                       done_next;
`ifdef BRAM_DUMP_HEADER_EN
  logic                       hdr_sel, hdr_sel_next;
`endif

  function automatic logic signed [FRAME_W-1:0] sign_extend(input logic [NB_DATA-1:0] d);
    logic signed [NB_DATA-1:0] s;
    s = d;
    return FRAME_W'(s);
  endfunction

  // Terminate on compare so DEPTH == 2**NB_ADDR never relies on wrap-around.
  assign last = (addr == NB_ADDR'(DEPTH - 1));

  always_comb begin
    state_next = state;
    addr_next  = addr;
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    done_next  = 1'b0;
`ifdef BRAM_DUMP_HEADER_EN
    hdr_sel_next = hdr_sel;
`endif
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          addr_next = '0;
`ifdef BRAM_DUMP_HEADER_EN
          hdr_sel_next = 1'b0;
          state_next   = ST_HEADER;
`else
          state_next   = ST_READ;
`endif
        end
      end
`ifdef BRAM_DUMP_HEADER_EN
      ST_HEADER: begin
        if (tx_idle) begin
          tx_valid = 1'b1;
          tx_byte  = hdr_sel ? SYNC_LO : SYNC_HI;
          if (hdr_sel) state_next = ST_READ;
          else         hdr_sel_next = 1'b1;
        end
      end
`endif
      ST_READ: state_next = ST_WAIT;
      ST_WAIT: state_next = ST_SEND_HI;
      ST_SEND_HI: begin
        if (tx_idle) begin
          tx_valid   = 1'b1;
          tx_byte    = sample[15:8];
          state_next = ST_SEND_LO;
        end
      end
      ST_SEND_LO: begin
        if (tx_idle) begin
          tx_valid   = 1'b1;
          tx_byte    = sample[7:0];
          state_next = ST_NEXT;
        end
      end
      ST_NEXT: begin
        // The last word only completes once its stop bit has left the line.
        if (last) begin
          if (tx_idle) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          addr_next  = addr + NB_ADDR'(1);
          state_next = ST_READ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      addr          <= '0;
      o_read_addr   <= '0;
      o_read_enable <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
`ifdef BRAM_DUMP_HEADER_EN
      hdr_sel       <= 1'b0;
`endif
    end else begin
      state         <= state_next;
      addr          <= addr_next;
      o_read_enable <= (state_next == ST_READ);
      if (state_next == ST_READ) o_read_addr <= addr_next;
      o_busy        <= (state_next != ST_IDLE);
      o_done        <= done_next;
`ifdef BRAM_DUMP_HEADER_EN
      hdr_sel       <= hdr_sel_next;
`endif
    end
  end

  // BRAM data is valid during WAIT, one cycle after the read strobe.
  always_ff @(posedge clock) begin
    if (state == ST_WAIT) sample <= sign_extend(i_read_data);
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clock  (clock),
    .i_reset(i_reset),
    .data   (tx_byte),
    .valid  (tx_valid),
    .tx     (o_tx),
    .idle   (tx_idle)
  );

endmodule

// File: tb/tb_bram_uart_dump.sv
// Bench for bram_uart_dump: table-driven frames checked by a UART-decoding
// scoreboard, plus restart-while-busy and mid-byte reset sequences.
module tb_bram_uart_dump;

  localparam int NB_ADDR = 2;
  localparam int NB_DATA = 14;
  localparam int DEPTH   = 4;
  localparam int CPB     = 4;

  logic               clock;
  logic               i_reset;
  logic               i_start;
  logic [NB_ADDR-1:0] o_read_addr;
  logic               o_read_enable;
  logic [NB_DATA-1:0] i_read_data;
  logic               o_tx;
  logic               o_busy;
  logic               o_done;

  bram_uart_dump #(
    .NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA), .DEPTH(DEPTH), .CLKS_PER_BIT(CPB)
  ) dut (
    .clock        (clock),
    .i_reset      (i_reset),
    .i_start      (i_start),
    .o_read_addr  (o_read_addr),
    .o_read_enable(o_read_enable),
    .i_read_data  (i_read_data),
    .o_tx         (o_tx),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [NB_DATA-1:0] data;
    logic [7:0]         hi;
    logic [7:0]         lo;
  } vec_t;

  vec_t               tab [8];
  logic [NB_DATA-1:0] mem [DEPTH];
  logic [7:0]         exp_q [$];
  int                 re_log [$];
  int                 checks = 0;
  int                 failures = 0;
  int                 done_cnt = 0;
  int                 rx_bytes = 0;
  bit                 rx_active = 0;
  int                 rx_cnt = 0;

  // One-cycle-latency BRAM model
  always @(posedge clock) begin
    if (o_read_enable) i_read_data <= mem[o_read_addr];
  end

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitors: UART decoder with per-bit hold check, read strobe log, done pulses.
  initial begin : monitor
    logic [7:0] rx_byte;
    bit         bit_ok;
    bit         re_prev;
    bit         done_prev;
    logic [7:0] e;
    int         bi;
    int         ph;
    rx_byte = 8'h00; bit_ok = 1'b1; re_prev = 1'b0; done_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (i_reset) begin
        rx_active = 0;
        re_prev   = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (o_read_enable) begin
          checks++;
          if (re_prev) begin
            failures++;
            $display("FAIL read_enable_width actual=2+ cycles required=1 cycle");
          end
          re_log.push_back(int'(o_read_addr));
        end
        re_prev = o_read_enable;
        if (o_done) begin
          done_cnt++;
          checks++;
          if (done_prev) begin
            failures++;
            $display("FAIL done_width actual=2+ cycles required=1 cycle");
          end
        end
        done_prev = o_done;
        if (!rx_active) begin
          if (o_tx === 1'b0) begin
            rx_active = 1;
            rx_cnt    = 1;
            bit_ok    = 1'b1;
            rx_byte   = 8'h00;
          end
        end else begin
          bi = rx_cnt / CPB;
          ph = rx_cnt % CPB;
          if (bi == 0) begin
            if (o_tx !== 1'b0) bit_ok = 1'b0;
          end else if (bi <= 8) begin
            if (ph == 0) rx_byte[bi-1] = o_tx;
            else if (o_tx !== rx_byte[bi-1]) bit_ok = 1'b0;
          end else begin
            if (o_tx !== 1'b1) bit_ok = 1'b0;
          end
          rx_cnt++;
          if (rx_cnt == 10 * CPB) begin
            rx_active = 0;
            rx_bytes++;
            checks++;
            if (!bit_ok) begin
              failures++;
              $display("FAIL bit_timing byte %0d actual=unstable required=each bit %0d cycles",
                       rx_bytes, CPB);
            end
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL uart_byte actual=%02h required=no byte", rx_byte);
            end else begin
              e = exp_q.pop_front();
              if (rx_byte !== e) begin
                failures++;
                $display("FAIL uart_byte actual=%02h required=%02h", rx_byte, e);
              end
            end
          end
        end
      end
    end
  end

  task automatic push_frame(input int base);
`ifdef BRAM_DUMP_HEADER_EN
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
`endif
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = tab[base+i].data;
      exp_q.push_back(tab[base+i].hi);
      exp_q.push_back(tab[base+i].lo);
    end
  endtask

  task automatic pulse_start();
    @(posedge clock); #1 i_start = 1'b1;
    @(posedge clock); #1 i_start = 1'b0;
  endtask

  task automatic run_frame(input int base, input bit restart);
    int d0;
    int rb0;
    int n;
    push_frame(base);
    re_log.delete();
    d0  = done_cnt;
    rb0 = rx_bytes;
    pulse_start();
    if (restart) begin
      for (n = 0; n < 2000 && !(rx_bytes == rb0 + 2 && rx_active); n++) @(posedge clock);
      chk("reach_byte3", n < 2000, 1);
      pulse_start();
    end
    for (n = 0; n < 3000 && done_cnt == d0; n++) @(posedge clock);
    chk("done_seen", done_cnt > d0, 1);
    #1 chk("tx_idle_after_done", o_tx, 1);
    chk("busy_low_after_done", o_busy, 0);
    repeat (100) begin
      @(posedge clock); #1;
      if (o_tx !== 1'b1) break;
    end
    chk("tx_stays_idle", o_tx, 1);
    chk("done_count", done_cnt, d0 + 1);
    chk("bytes_left", exp_q.size(), 0);
    chk("read_count", re_log.size(), DEPTH);
    for (int i = 0; i < re_log.size(); i++) chk("read_addr", re_log[i], i);
  endtask

  initial begin : main
    int d0;
    int rb0;
    int n;
    tab[0] = '{14'h0001, 8'h00, 8'h01};
    tab[1] = '{14'h1FFF, 8'h1F, 8'hFF};
    tab[2] = '{14'h2000, 8'hE0, 8'h00};
    tab[3] = '{14'h3FFF, 8'hFF, 8'hFF};
    tab[4] = '{14'h1234, 8'h12, 8'h34};
    tab[5] = '{14'h2ABC, 8'hEA, 8'hBC};
    tab[6] = '{14'h0000, 8'h00, 8'h00};
    tab[7] = '{14'h3000, 8'hF0, 8'h00};

    i_reset = 1'b1;
    i_start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_tx", o_tx, 1);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_read_enable", o_read_enable, 0);
    chk("reset_read_addr", o_read_addr, 0);
    @(posedge clock); #1 i_reset = 1'b0;
    repeat (3) @(posedge clock);

    run_frame(0, 1'b0);
    run_frame(4, 1'b0);
    run_frame(0, 1'b1);

    // Reset in the middle of the second byte
    push_frame(4);
    d0  = done_cnt;
    rb0 = rx_bytes;
    pulse_start();
    for (n = 0; n < 2000 && !(rx_bytes == rb0 + 1 && rx_active && rx_cnt >= 10); n++)
      @(posedge clock);
    chk("reach_byte2", n < 2000, 1);
    @(posedge clock); #2 i_reset = 1'b1;
    #1;
    chk("abort_tx", o_tx, 1);
    chk("abort_busy", o_busy, 0);
    chk("abort_read_enable", o_read_enable, 0);
    @(posedge clock); #1 i_reset = 1'b0;
    exp_q.delete();
    repeat (100) @(posedge clock);
    #1;
    chk("no_done_after_abort", done_cnt, d0);
    chk("no_bytes_after_abort", rx_bytes, rb0 + 1);
    chk("tx_idle_after_abort", o_tx, 1);

    run_frame(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
